div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Controller between the EX stage and an iterative unsigned divider core. Handles DIV, DIVU, REM and REMU.
- Decodes sign handling and sequences the core through a start/done handshake. Applies RISC-V special cases (divide-by-zero, signed overflow) without using the core.
- Keeps a one-entry result cache so a DIV/REM pair on the same operands costs a single core run.
- Drives the pipeline stall and returns a corrected XLEN result to the EX result mux.

Parameters:
- XLEN, 32: operand/result width.
- CACHE_EN, 1: 1 enables the one-entry result cache; 0 makes every non-special request use the core.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  EX holds a divide-class instruction. Held high, with operands stable, while stall=1.
- div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  XLEN  rs1 after forwarding.
- divisor  input  XLEN  rs2 after forwarding.
- flush  input  1  kill the in-flight request (branch redirect).
- stall  output  1  freeze IF/ID/ID-EX and bubble EX/MEM.
- result_valid  output  1  result holds the final value this cycle.
- result  output  XLEN  quotient or remainder, sign-corrected.
- core_start  output  1  one-cycle start pulse to the core.
- core_abort  output  1  one-cycle pulse that cancels the core.
- core_dividend  output  XLEN  magnitude of the dividend, registered.
- core_divisor  output  XLEN  magnitude of the divisor, registered.
- core_done  input  1  core result valid, one-cycle pulse.
- core_quotient  input  XLEN  unsigned quotient.
- core_remainder  input  XLEN  unsigned remainder.

Behaviour:
- Reset:
  - All registered outputs are 0. State is IDLE and cache_valid is 0.
  - reset asserting mid-operation returns to IDLE immediately. No core_abort is issued; the core shares the reset.
- States: IDLE, START, BUSY, DONE.
- Signed flag: sgn = ~div_op[0]. is_rem = div_op[1].
- Fast path, IDLE with req_valid=1, combinational, 0 extra cycles. result_valid=1, stall=0, no state change. Conditions in priority order:
  - divisor==0: quotient = all ones, remainder = dividend.
  - sgn && dividend==100..0 && divisor==all ones: quotient = dividend, remainder = 0.
  - CACHE_EN && cache_valid && dividend, divisor and sgn all equal the cached values: return the cached quotient or remainder.
- Slow path, IDLE with req_valid=1 and no fast-path condition:
  - stall=1 in this cycle.
  - Register the operand magnitudes (two's-complement negate if sgn and MSB set), neg_q = sgn & (sign(dividend) ^ sign(divisor)), neg_r = sgn & sign(dividend), is_rem and the raw operands. Go to START.
- START: core_start=1 for exactly one cycle, stall=1, then go to BUSY.
- BUSY: stall=1 while waiting.
  - On core_done: result_reg = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo).
  - Cache update: raw operands, sgn, and the corrected quotient and remainder; cache_valid=1.
  - Go to DONE.
- DONE: result_valid=1, result=result_reg, stall=0 for one cycle (EX/MEM captures), then go to IDLE.
- Latency: core latency + 3 cycles from request to result_valid (IDLE, START, BUSY with done, DONE).
- req_valid=0 in IDLE: stall=0, result_valid=0, result=0.
- stall is combinational from state and inputs: (IDLE & req_valid & ~fast) | START | BUSY.
- Flush:
  - In START or BUSY: go to IDLE next cycle and pulse core_abort=1 for one cycle. The cache is not updated, and stall drops the cycle after flush.
  - In DONE: no effect; the result was already presented.
  - In IDLE: suppresses result_valid and stall in that cycle.
- core_done while not in BUSY is ignored.
- A flush and core_done in the same cycle: flush wins, and the cache is not written.
- Cache: not cleared by flush; cleared only by reset. Widths are XLEN throughout; negation is modulo 2^XLEN.

Test Plan:
- DIV, -7 / 2, core returns q=3 r=1 → result=0xFFFFFFFD, result_valid in DONE; stall high for exactly START, BUSY and the request cycle.
- REM issued right after a DIV with the same operands (-7, 2) → cache hit in the same cycle, result=0xFFFFFFFF, stall=0, no core_start.
- DIVU x/0 with x=0x1234 → result=0xFFFFFFFF with zero stall; REMU x/0 → 0x1234; no core_start.
- DIV 0x80000000 / 0xFFFFFFFF → result=0x80000000, 0 cycles; REM with the same operands → 0.
- DIV issued, flush asserted on the 2nd BUSY cycle → core_abort pulses once, state goes to IDLE, a later core_done is ignored, cache_valid is unchanged, and the next identical request uses the core.
- reset low mid-BUSY → all outputs 0 at once, cache_valid=0; after release, a DIVU 100/7 → 14.

Source files
------------

// File: rtl/div_sequencer.sv
// Sequencer between EX and an iterative unsigned divider core: sign handling, RISC-V special
// cases, a one-entry result cache, pipeline stall and the sign-corrected result.
module div_sequencer #(
    parameter int unsigned XLEN     = 32,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            req_valid_i,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            core_start_o,
    output logic            core_abort_o,
    output logic [XLEN-1:0] core_dividend_o,
    output logic [XLEN-1:0] core_divisor_o,
    input  logic            core_done_i,
    input  logic [XLEN-1:0] core_quotient_i,
    input  logic [XLEN-1:0] core_remainder_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StBusy  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic            sgn_q, sgn_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] mag_a_q, mag_a_d;
    logic [XLEN-1:0] mag_b_q, mag_b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            cache_valid_q, cache_valid_d;
    logic [XLEN-1:0] cache_a_q, cache_a_d;
    logic [XLEN-1:0] cache_b_q, cache_b_d;
    logic            cache_sgn_q, cache_sgn_d;
    logic [XLEN-1:0] cache_quo_q, cache_quo_d;
    logic [XLEN-1:0] cache_rem_q, cache_rem_d;

    logic            sgn;
    logic            is_rem;
    logic            req_act;
    logic            div_zero;
    logic            overflow;
    logic            cache_hit;
    logic            fast;
    logic [XLEN-1:0] fast_result;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] corr_quo;
    logic [XLEN-1:0] corr_rem;
    logic            in_idle;
    logic            in_flight;

    assign sgn    = ~div_op_i[0];
    assign is_rem = div_op_i[1];

    // A flushed request, or one seen while reset is held, is treated as absent.
    assign req_act = req_valid_i & ~flush_i & reset_ni;

    assign div_zero  = (divisor_i == '0);
    assign overflow  = sgn & (dividend_i == IntMin) & (divisor_i == AllOnes);
    assign cache_hit = CACHE_EN & cache_valid_q & (cache_a_q == dividend_i) &
                       (cache_b_q == divisor_i) & (cache_sgn_q == sgn);
    assign fast      = div_zero | overflow | cache_hit;

    always_comb begin
        fast_result = '0;
        if (div_zero) begin
            fast_result = is_rem ? dividend_i : AllOnes;
        end else if (overflow) begin
            fast_result = is_rem ? '0 : dividend_i;
        end else if (cache_hit) begin
            fast_result = is_rem ? cache_rem_q : cache_quo_q;
        end
    end

    assign mag_a = (sgn && dividend_i[XLEN-1]) ? ('0 - dividend_i) : dividend_i;
    assign mag_b = (sgn && divisor_i[XLEN-1])  ? ('0 - divisor_i)  : divisor_i;

    assign corr_quo = neg_quo_q ? ('0 - core_quotient_i)  : core_quotient_i;
    assign corr_rem = neg_rem_q ? ('0 - core_remainder_i) : core_remainder_i;

    assign in_idle   = (state_q == StIdle);
    assign in_flight = (state_q == StStart) || (state_q == StBusy);

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        sgn_d         = sgn_q;
        is_rem_d      = is_rem_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        mag_a_d       = mag_a_q;
        mag_b_d       = mag_b_q;
        result_d      = result_q;
        cache_valid_d = cache_valid_q;
        cache_a_d     = cache_a_q;
        cache_b_d     = cache_b_q;
        cache_sgn_d   = cache_sgn_q;
        cache_quo_d   = cache_quo_q;
        cache_rem_d   = cache_rem_q;

        unique case (state_q)
            StIdle: begin
                if (req_act && !fast) begin
                    state_d   = StStart;
                    op_a_d    = dividend_i;
                    op_b_d    = divisor_i;
                    sgn_d     = sgn;
                    is_rem_d  = is_rem;
                    neg_quo_d = sgn & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                    neg_rem_d = sgn & dividend_i[XLEN-1];
                    mag_a_d   = mag_a;
                    mag_b_d   = mag_b;
                end
            end
            StStart: begin
                state_d = flush_i ? StIdle : StBusy;
            end
            StBusy: begin
                // Flush beats a coincident core_done; the cache keeps its old entry.
                if (flush_i) begin
                    state_d = StIdle;
                end else if (core_done_i) begin
                    state_d       = StDone;
                    result_d      = is_rem_q ? corr_rem : corr_quo;
                    cache_valid_d = CACHE_EN;
                    cache_a_d     = op_a_q;
                    cache_b_d     = op_b_q;
                    cache_sgn_d   = sgn_q;
                    cache_quo_d   = corr_quo;
                    cache_rem_d   = corr_rem;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StIdle;
            op_a_q        <= '0;
            op_b_q        <= '0;
            sgn_q         <= 1'b0;
            is_rem_q      <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            mag_a_q       <= '0;
            mag_b_q       <= '0;
            result_q      <= '0;
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_sgn_q   <= 1'b0;
            cache_quo_q   <= '0;
            cache_rem_q   <= '0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            sgn_q         <= sgn_d;
            is_rem_q      <= is_rem_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            mag_a_q       <= mag_a_d;
            mag_b_q       <= mag_b_d;
            result_q      <= result_d;
            cache_valid_q <= cache_valid_d;
            cache_a_q     <= cache_a_d;
            cache_b_q     <= cache_b_d;
            cache_sgn_q   <= cache_sgn_d;
            cache_quo_q   <= cache_quo_d;
            cache_rem_q   <= cache_rem_d;
        end
    end

    always_comb begin
        stall_o        = in_flight | (in_idle & req_act & ~fast);
        result_valid_o = (state_q == StDone) | (in_idle & req_act & fast);
        result_o       = '0;
        if (state_q == StDone) begin
            result_o = result_q;
        end else if (in_idle && req_act && fast) begin
            result_o = fast_result;
        end
    end

    assign core_start_o    = (state_q == StStart);
    assign core_abort_o    = in_flight & flush_i;
    assign core_dividend_o = mag_a_q;
    assign core_divisor_o  = mag_b_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized bench for div_sequencer with a behavioural core model and a plain-arithmetic
// reference for RISC-V DIV/DIVU/REM/REMU plus a model of the one-entry cache.
module tb_div_sequencer;

    localparam logic [1:0] OpDiv  = 2'd0;
    localparam logic [1:0] OpDivu = 2'd1;
    localparam logic [1:0] OpRem  = 2'd2;
    localparam logic [1:0] OpRemu = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic        core_start;
    logic        core_abort;
    logic [31:0] core_dividend;
    logic [31:0] core_divisor;
    logic        core_done = 1'b0;
    logic [31:0] core_quotient = '0;
    logic [31:0] core_remainder = '0;

    int checks = 0;
    int failures = 0;

    // Core model state
    int          start_cnt = 0;
    int          abort_cnt = 0;
    int          done_cnt = 0;
    int          core_lat = 1;
    bit          ignore_abort = 1'b0;
    int          cnt = 0;
    logic [31:0] cd, cs;

    // Cache model
    bit          cv = 1'b0;
    logic [31:0] ca, cb;
    bit          csgn;

    div_sequencer #(.XLEN(32), .CACHE_EN(1'b1)) dut (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .req_valid_i      (req_valid),
        .div_op_i         (div_op),
        .dividend_i       (dividend),
        .divisor_i        (divisor),
        .flush_i          (flush),
        .stall_o          (stall),
        .result_valid_o   (result_valid),
        .result_o         (result),
        .core_start_o     (core_start),
        .core_abort_o     (core_abort),
        .core_dividend_o  (core_dividend),
        .core_divisor_o   (core_divisor),
        .core_done_i      (core_done),
        .core_quotient_i  (core_quotient),
        .core_remainder_i (core_remainder)
    );

    always #5 clk = ~clk;

    // Unsigned divider core: samples start at negedge, raises done 'core_lat' cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0;
            core_done = 1'b0;
        end else begin
            if (core_abort) begin
                abort_cnt++;
                if (!ignore_abort) cnt = 0;
            end
            core_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    done_cnt++;
                    core_quotient = cd / cs;
                    core_remainder = cd % cs;
                end
            end
            if (core_start) begin
                start_cnt++;
                cd = core_dividend;
                cs = core_divisor;
                cnt = core_lat;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        if (b == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] mag(input bit sgn, input logic [31:0] x);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    task automatic run_req(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat);
        logic [31:0] exp;
        bit sgn, special, hit, got;
        int n, s0;
        sgn = ~op[0];
        exp = ref_div(op, a, b);
        special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit = !special && cv && a == ca && b == cb && sgn == csgn;
        core_lat = lat;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        div_op = op;
        dividend = a;
        divisor = b;
        s0 = start_cnt;
        @(negedge clk);
        if (special || hit) begin
            check_eq({tag, ":fast_rv"}, {31'd0, result_valid}, 32'd1);
            check_eq({tag, ":fast_res"}, result, exp);
            check_eq({tag, ":fast_stall"}, {31'd0, stall}, 32'd0);
            check_eq({tag, ":fast_start"}, {31'd0, core_start}, 32'd0);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(negedge clk);
            check_eq({tag, ":fast_nostart"}, {31'd0, core_start}, 32'd0);
        end else begin
            check_eq({tag, ":req_stall"}, {31'd0, stall}, 32'd1);
            check_eq({tag, ":req_rv"}, {31'd0, result_valid}, 32'd0);
            n = 1;
            got = 1'b0;
            for (int i = 0; i < 64 && !got; i++) begin
                @(negedge clk);
                if (result_valid) got = 1'b1;
                else if (stall) n++;
            end
            check_eq({tag, ":done_seen"}, {31'd0, got}, 32'd1);
            if (got) begin
                check_eq({tag, ":res"}, result, exp);
                check_eq({tag, ":done_stall"}, {31'd0, stall}, 32'd0);
                check_eq({tag, ":stall_cycles"}, n, lat + 2);
                check_eq({tag, ":core_dvd"}, core_dividend, mag(sgn, a));
                check_eq({tag, ":core_dvs"}, core_divisor, mag(sgn, b));
                check_eq({tag, ":starts"}, start_cnt - s0, 32'd1);
                cv = 1'b1;
                ca = a;
                cb = b;
                csgn = sgn;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b, pa, pb;
        logic [1:0]  op;
        int          s0, d0, sel;
        bit          rv_seen;

        req_valid = 1'b0;
        div_op = '0;
        dividend = '0;
        divisor = '0;
        flush = 1'b0;
        pa = 32'd7;
        pb = 32'd3;

        repeat (2) @(negedge clk);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_rv", {31'd0, result_valid}, 32'd0);
        check_eq("rst_res", result, 32'd0);
        check_eq("rst_start", {31'd0, core_start}, 32'd0);
        check_eq("rst_abort", {31'd0, core_abort}, 32'd0);
        check_eq("rst_cdvd", core_dividend, 32'd0);
        check_eq("rst_cdvs", core_divisor, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_req("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 3);
        run_req("rem_m7_2_hit", OpRem, 32'hFFFF_FFF9, 32'd2, 3);
        run_req("divu_by0", OpDivu, 32'h1234, 32'd0, 2);
        run_req("remu_by0", OpRemu, 32'h1234, 32'd0, 2);
        run_req("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 2);
        run_req("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 2);

        // Flush in IDLE suppresses the fast result
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        flush = 1'b1;
        div_op = OpDivu;
        dividend = 32'h55;
        divisor = 32'd0;
        @(negedge clk);
        check_eq("idle_flush_rv", {31'd0, result_valid}, 32'd0);
        check_eq("idle_flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;

        // Flush on the second BUSY cycle; the core keeps running and its done must be ignored
        core_lat = 6;
        ignore_abort = 1'b1;
        s0 = abort_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        div_op = OpDiv;
        dividend = 32'd100;
        divisor = 32'hFFFF_FFFD;
        @(negedge clk);
        check_eq("fl_req_stall", {31'd0, stall}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check_eq("fl_abort", {31'd0, core_abort}, 32'd1);
        check_eq("fl_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("fl_after_stall", {31'd0, stall}, 32'd0);
        check_eq("fl_after_abort", {31'd0, core_abort}, 32'd0);
        rv_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (result_valid || stall || core_start) rv_seen = 1'b1;
        end
        check_eq("fl_ignored_done", {31'd0, rv_seen}, 32'd0);
        check_eq("fl_abort_once", abort_cnt - s0, 32'd1);
        check_eq("fl_core_done_fired", done_cnt - d0, 32'd1);
        ignore_abort = 1'b0;
        run_req("fl_cache_kept", OpRem, 32'hFFFF_FFF9, 32'd2, 1);
        run_req("fl_retry", OpDiv, 32'd100, 32'hFFFF_FFFD, 2);

        // Reset mid-BUSY clears outputs and the cache
        run_req("divu_pre", OpDivu, 32'd100, 32'd7, 2);
        core_lat = 10;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        div_op = OpDivu;
        dividend = 32'd200;
        divisor = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("mid_rst_rv", {31'd0, result_valid}, 32'd0);
        check_eq("mid_rst_res", result, 32'd0);
        check_eq("mid_rst_start", {31'd0, core_start}, 32'd0);
        check_eq("mid_rst_cdvd", core_dividend, 32'd0);
        check_eq("mid_rst_cdvs", core_divisor, 32'd0);
        req_valid = 1'b0;
        cv = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_req("post_rst_divu", OpDivu, 32'd100, 32'd7, 2);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                2, 3: begin
                    a = pa;
                    b = pb;
                end
                4: begin
                    a = $urandom_range(0, 200);
                    b = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) a = 32'd0 - a;
                    if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
                end
                5: b = b >> $urandom_range(16, 31);
                default: ;
            endcase
            pa = a;
            pb = b;
            run_req("rnd", op, a, b, $urandom_range(1, 4));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
